operand_prep_pipe: RTL

- Parametrised successor to the decode-stage operand preparation block: register file, two read ports, immediate sign-extension and ALU-source mux, all in one block.
- Adds a registered output stage with a valid/ready handshake, same-cycle write-to-read bypass, and an optional hardwired zero register (XZR).
- A held (stalled) output is kept coherent with later register writes.
- Sits between instruction decode and the ALU/execute stage.

---
 rtl/operand_prep_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/operand_prep_pipe.sv
// Decode-to-execute operand preparation: register file, two bypassed read ports, immediate sign-extension, ALU-source mux.
// Latency: 1 cycle from accept to out_valid. Backpressure: in_ready = !out_valid || out_ready, no skid buffer.
// While an output is held, writes to its source registers are folded into it so it never goes stale.
module operand_prep_pipe #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int IMM_WIDTH   = 32,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] reg1,
    input  logic [ADDR_WIDTH-1:0] reg2,
    input  logic                  alu_src,
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] output1,
    output logic [DATA_WIDTH-1:0] output2,
    output logic [DATA_WIDTH-1:0] store_data
);

    localparam int                  DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '1;
    localparam bit                  HAS_XZR  = (ZERO_REG_EN != 0);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out1_q, out1_d;
    logic [DATA_WIDTH-1:0] out2_q, out2_d;
    logic [DATA_WIDTH-1:0] store_q, store_d;
    logic [ADDR_WIDTH-1:0] src1_q, src1_d;
    logic [ADDR_WIDTH-1:0] src2_q, src2_d;
    logic                  alu_src_q, alu_src_d;

    logic                  wr_en;
    logic                  accept;
    logic                  rd1_zero, rd2_zero;
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic [DATA_WIDTH-1:0] imm_ext;

    // Writes to the hardwired zero register are dropped before they reach anything.
    assign wr_en    = reg_write && !(HAS_XZR && (write_register == ZERO_IDX));
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign rd1_zero = HAS_XZR && (reg1 == ZERO_IDX);
    assign rd2_zero = HAS_XZR && (reg2 == ZERO_IDX);

    assign rd1 = rd1_zero                         ? '0         :
                 (wr_en && write_register == reg1) ? write_data :
                                                     regs_q[reg1];
    assign rd2 = rd2_zero                         ? '0         :
                 (wr_en && write_register == reg2) ? write_data :
                                                     regs_q[reg2];

    assign imm_ext = DATA_WIDTH'($signed(imm));

    always_comb begin
        out_valid_d = out_valid_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        store_d     = store_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        alu_src_d   = alu_src_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out1_d      = rd1;
            store_d     = rd2;
            out2_d      = alu_src ? imm_ext : rd2;
            src1_d      = reg1;
            src2_d      = reg2;
            alu_src_d   = alu_src;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && wr_en) begin
            // Stalled: refresh captured register values; an immediate in output2 stays.
            if (write_register == src1_q) begin
                out1_d = write_data;
            end
            if (write_register == src2_q) begin
                store_d = write_data;
                if (!alu_src_q) begin
                    out2_d = write_data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
            store_q     <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            alu_src_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            store_q     <= store_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            alu_src_q   <= alu_src_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_register] <= write_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign output1    = out1_q;
    assign output2    = out2_q;
    assign store_data = store_q;

endmodule
